mont_exp: RTL and testbench

//  Left-to-right square-and-multiply modular exponentiation sequencer: result = x^e mod n.

---
 rtl/mont_exp_pkg.sv | 23 ++
 rtl/mont_exp_if.sv | 41 ++++
 rtl/mont_exp_bit_iter.sv | 52 +++++
 rtl/mont_exp.sv | 218 +++++++++++++++++++++
 tb/tb_mont_exp.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mont_exp_pkg.sv
// Shared types and default sizes for the mont_exp modular exponentiation sequencer.
package mont_exp_pkg;

  localparam int WIDTH_DEF = 1024;
  localparam int E_W_DEF   = 1024;

  typedef enum logic [2:0] {
    IDLE,
    TOMONT,
    SQUARE,
    MULT,
    NEXT,
    FROMMONT,
    DONE
  } state_e;

  // Each Montgomery multiplication is a one-cycle ISSUE followed by a WAIT for mm_done.
  typedef enum logic {
    ISSUE,
    WAIT
  } phase_e;

endpackage

// File: rtl/mont_exp_if.sv
// Host-side command/result and multiplier-side handshake signals of mont_exp.
interface mont_exp_if
  import mont_exp_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int E_W   = E_W_DEF,
  parameter int LEN_W = $clog2(E_W) + 1
);

  logic             start;
  logic [WIDTH-1:0] x;
  logic [E_W-1:0]   e;
  logic [LEN_W-1:0] e_len;
  logic [WIDTH-1:0] n;
  logic [WIDTH-1:0] r_n;
  logic [WIDTH-1:0] r2_n;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic [31:0]      cycles;

  logic             mm_start;
  logic [WIDTH-1:0] mm_a;
  logic [WIDTH-1:0] mm_b;
  logic [WIDTH-1:0] mm_m;
  logic [WIDTH:0]   mm_result;
  logic             mm_done;

  // Sequencer view.
  modport slave (
    input  start, x, e, e_len, n, r_n, r2_n, mm_result, mm_done,
    output busy, done, result, cycles, mm_start, mm_a, mm_b, mm_m
  );

  // Upstream wrapper plus multiplier view.
  modport master (
    output start, x, e, e_len, n, r_n, r2_n, mm_result, mm_done,
    input  busy, done, result, cycles, mm_start, mm_a, mm_b, mm_m
  );

endinterface

// File: rtl/mont_exp_bit_iter.sv
// Exponent bit iterator: latches e and the clamped length, walks the index from MSB to bit 0.
module exp_bit_iter
  import mont_exp_pkg::*;
#(
  parameter int E_W   = E_W_DEF,
  parameter int LEN_W = $clog2(E_W) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  logic [E_W-1:0]   i_e,
  input  logic [LEN_W-1:0] i_len,
  input  logic             i_dec,
  output logic             o_cur_bit,
  output logic             o_is_last,
  output logic             o_empty
);

  localparam int               IDX_W   = (E_W > 1) ? $clog2(E_W) : 1;
  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(E_W);

  logic [E_W-1:0]   r_e;
  logic [IDX_W-1:0] r_idx;
  logic             r_empty;

  logic [LEN_W-1:0] w_len;
  logic [LEN_W-1:0] w_len_m1;

  // Lengths beyond the register width behave as a full-width exponent.
  assign w_len    = (i_len > MAX_LEN) ? MAX_LEN : i_len;
  assign w_len_m1 = w_len - 1'b1;

  // NOTE: sequential state is assigned with <= so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_e     <= '0;
      r_idx   <= '0;
      r_empty <= 1'b1;
    end else if (i_load) begin
      r_e     <= i_e;
      r_idx   <= w_len_m1[IDX_W-1:0];
      r_empty <= (w_len == '0);
    end else if (i_dec) begin
      r_idx   <= r_idx - 1'b1;
    end
  end

  assign o_cur_bit = r_e[r_idx];
  assign o_is_last = (r_idx == '0);
  assign o_empty   = r_empty;

endmodule

// File: rtl/mont_exp.sv
// Left-to-right square-and-multiply sequencer driving an external Montgomery multiplier.
// Optional start-to-done cycle counter is built when MONT_EXP_CYCLE_CNT_EN is defined.
module mont_exp
  import mont_exp_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int E_W   = E_W_DEF,
  parameter int LEN_W = $clog2(E_W) + 1
) (
  input logic       clk,
  input logic       reset,
  mont_exp_if.slave bus
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  state_e           r_state;
  phase_e           r_phase;
  logic             r_mm_start;
  logic [WIDTH-1:0] r_mm_a;
  logic [WIDTH-1:0] r_mm_b;
  logic [WIDTH-1:0] r_mm_m;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_xt;
  logic [WIDTH-1:0] r_result;
  logic             r_done;

  state_e           w_state_nx;
  phase_e           w_phase_nx;
  logic             w_mm_start_nx;
  logic [WIDTH-1:0] w_mm_a_nx;
  logic [WIDTH-1:0] w_mm_b_nx;
  logic [WIDTH-1:0] w_mm_m_nx;
  logic [WIDTH-1:0] w_a_nx;
  logic [WIDTH-1:0] w_xt_nx;
  logic [WIDTH-1:0] w_result_nx;
  logic             w_done_nx;
  logic             w_iter_load;
  logic             w_iter_dec;
  logic             w_accept;
  logic             w_mm_ret;
  logic [WIDTH-1:0] w_prod;
  logic             w_cur_bit;
  logic             w_is_last;
  logic             w_empty;

  assign w_accept = (r_state == IDLE) && bus.start;
  // Products arriving outside WAIT belong to nobody and are dropped.
  assign w_mm_ret = (r_phase == WAIT) && bus.mm_done;
  assign w_prod   = bus.mm_result[WIDTH-1:0];

  exp_bit_iter #(
    .E_W   (E_W),
    .LEN_W (LEN_W)
  ) u_iter (
    .clk       (clk),
    .reset     (reset),
    .i_load    (w_iter_load),
    .i_e       (bus.e),
    .i_len     (bus.e_len),
    .i_dec     (w_iter_dec),
    .o_cur_bit (w_cur_bit),
    .o_is_last (w_is_last),
    .o_empty   (w_empty)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_phase    <= ISSUE;
      r_mm_start <= 1'b0;
      r_mm_a     <= '0;
      r_mm_b     <= '0;
      r_mm_m     <= '0;
      r_a        <= '0;
      r_xt       <= '0;
      r_result   <= '0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_nx;
      r_phase    <= w_phase_nx;
      r_mm_start <= w_mm_start_nx;
      r_mm_a     <= w_mm_a_nx;
      r_mm_b     <= w_mm_b_nx;
      r_mm_m     <= w_mm_m_nx;
      r_a        <= w_a_nx;
      r_xt       <= w_xt_nx;
      r_result   <= w_result_nx;
      r_done     <= w_done_nx;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_nx    = r_state;
    w_phase_nx    = r_phase;
    w_mm_start_nx = 1'b0;
    w_mm_a_nx     = r_mm_a;
    w_mm_b_nx     = r_mm_b;
    w_mm_m_nx     = r_mm_m;
    w_a_nx        = r_a;
    w_xt_nx       = r_xt;
    w_result_nx   = r_result;
    w_done_nx     = 1'b0;
    w_iter_load   = 1'b0;
    w_iter_dec    = 1'b0;

    // An ISSUE cycle always hands over to WAIT; operands stay put until the product returns.
    if (r_phase == ISSUE) begin
      w_phase_nx = WAIT;
    end

    unique case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_nx    = TOMONT;
          w_mm_start_nx = 1'b1;
          w_mm_a_nx     = bus.x;
          w_mm_b_nx     = bus.r2_n;
          w_mm_m_nx     = bus.n;
          w_a_nx        = bus.r_n;
          w_iter_load   = 1'b1;
        end
      end
      TOMONT: begin
        if (w_mm_ret) begin
          w_xt_nx       = w_prod;
          w_mm_start_nx = 1'b1;
          w_mm_a_nx     = r_a;
          if (w_empty) begin
            w_state_nx = FROMMONT;
            w_mm_b_nx  = ONE;
          end else begin
            w_state_nx = SQUARE;
            w_mm_b_nx  = r_a;
          end
        end
      end
      SQUARE: begin
        if (w_mm_ret) begin
          w_a_nx = w_prod;
          if (w_cur_bit) begin
            w_state_nx    = MULT;
            w_mm_start_nx = 1'b1;
            w_mm_a_nx     = w_prod;
            w_mm_b_nx     = r_xt;
          end else begin
            w_state_nx = NEXT;
          end
        end
      end
      MULT: begin
        if (w_mm_ret) begin
          w_a_nx     = w_prod;
          w_state_nx = NEXT;
        end
      end
      NEXT: begin
        w_mm_start_nx = 1'b1;
        w_mm_a_nx     = r_a;
        if (w_is_last) begin
          w_state_nx = FROMMONT;
          w_mm_b_nx  = ONE;
        end else begin
          w_state_nx = SQUARE;
          w_mm_b_nx  = r_a;
          w_iter_dec = 1'b1;
        end
      end
      FROMMONT: begin
        if (w_mm_ret) begin
          w_a_nx      = w_prod;
          w_result_nx = w_prod;
          w_done_nx   = 1'b1;
          w_state_nx  = DONE;
        end
      end
      DONE: begin
        w_state_nx = IDLE;
      end
      default: begin
        w_state_nx = IDLE;
      end
    endcase

    if (w_mm_start_nx) begin
      w_phase_nx = ISSUE;
    end
  end

  assign bus.busy     = (r_state != IDLE);
  assign bus.done     = r_done;
  assign bus.result   = r_result;
  assign bus.mm_start = r_mm_start;
  assign bus.mm_a     = r_mm_a;
  assign bus.mm_b     = r_mm_b;
  assign bus.mm_m     = r_mm_m;

`ifdef MONT_EXP_CYCLE_CNT_EN
  logic [31:0] r_cycles;

  // Counts the busy cycles before DONE, so the value is already final while done is high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cycles <= '0;
    end else if (w_accept) begin
      r_cycles <= '0;
    end else if ((r_state != IDLE) && (r_state != DONE) && (r_cycles != 32'hFFFF_FFFF)) begin
      r_cycles <= r_cycles + 32'd1;
    end
  end

  assign bus.cycles = r_cycles;
`else
  assign bus.cycles = 32'd0;
`endif

endmodule

// File: tb/tb_mont_exp.sv
// Directed and randomized bench for mont_exp with a behavioural Montgomery multiplier model.
module tb_mont_exp;

  localparam int WIDTH = 16;
  localparam int E_W   = 16;
  localparam int LEN_W = 5;

  logic clk = 1'b0;
  logic reset = 1'b1;

  always #5 clk = ~clk;

  mont_exp_if #(.WIDTH(WIDTH), .E_W(E_W), .LEN_W(LEN_W)) bus ();

  mont_exp #(.WIDTH(WIDTH), .E_W(E_W), .LEN_W(LEN_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Multiplier model state.
  int         mm_lat      = 1;
  int         mm_starts   = 0;
  int         mm_pend     = 0;
  int         mm_cnt      = 0;
  logic [WIDTH:0] mm_val  = '0;
  longint     cached_n    = 0;
  longint     cached_rinv = 0;
  int         done_pulses = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Inverse of R = 2^16 modulo n by direct search.
  function automatic longint r_inverse(input longint n);
    longint inv;
    inv = 0;
    for (longint r = 1; r < n; r++) begin
      if (((r << WIDTH) % n) == 1) begin
        inv = r;
        break;
      end
    end
    return inv;
  endfunction

  // x^ev mod n by repeated multiplication, ev being the low eff bits of e.
  function automatic longint modexp(input longint x, input longint e, input int eff, input longint n);
    longint ev;
    longint r;
    ev = (eff == 0) ? 0 : (e & ((longint'(1) << eff) - 1));
    r  = 1 % n;
    for (longint k = 0; k < ev; k++) r = (r * x) % n;
    return r;
  endfunction

  // Montgomery multiplier: a*b*R^-1 mod n, mm_done after mm_lat cycles, junk in the top bit.
  always @(negedge clk) begin
    longint prod;
    bus.mm_done = 1'b0;
    if (mm_pend != 0) begin
      mm_cnt--;
      if (mm_cnt == 0) begin
        bus.mm_done   = 1'b1;
        bus.mm_result = mm_val;
        mm_pend       = 0;
      end
    end
    if (bus.mm_start) begin
      if (longint'(bus.mm_m) != cached_n) begin
        cached_n    = longint'(bus.mm_m);
        cached_rinv = r_inverse(cached_n);
      end
      prod    = ((longint'(bus.mm_a) * longint'(bus.mm_b)) % cached_n) * cached_rinv % cached_n;
      mm_val  = {1'($urandom), WIDTH'(prod)};
      mm_pend = 1;
      mm_cnt  = mm_lat;
      mm_starts++;
    end
  end

  always @(negedge clk) begin
    if (bus.done) done_pulses++;
  end

  task automatic do_job(input string tag, input longint x, input longint e, input int len,
                        input longint n, input int lat, input bit start_mid, input longint want);
    int     eff;
    int     pop;
    int     nmm;
    longint exp_res;
    int     base_starts;
    int     base_done;
    bit     seen;
    longint mask;

    eff     = (len > E_W) ? E_W : len;
    mask    = (eff == 0) ? 0 : ((longint'(1) << eff) - 1);
    pop     = $countones(e & mask);
    nmm     = 2 + eff + pop;
    exp_res = modexp(x, e, eff, n);
    mm_lat  = lat;

    bus.x     = WIDTH'(x);
    bus.e     = E_W'(e);
    bus.e_len = LEN_W'(len);
    bus.n     = WIDTH'(n);
    bus.r_n   = WIDTH'((longint'(1) << WIDTH) % n);
    bus.r2_n  = WIDTH'((longint'(1) << (2 * WIDTH)) % n);
    base_starts = mm_starts;
    base_done   = done_pulses;

    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check({tag, ":busy_after_start"}, bus.busy, 1);

    if (start_mid) begin
      repeat (7) @(negedge clk);
      bus.x     = WIDTH'(x + 1);
      bus.e     = E_W'(e ^ 1);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
    end

    seen = 1'b0;
    for (int c = 0; c < 20000 && !seen; c++) begin
      @(negedge clk);
      if (bus.done) seen = 1'b1;
    end
    check({tag, ":done_seen"}, seen, 1);

    if (seen) begin
      check({tag, ":result"}, bus.result, exp_res);
      if (want >= 0) check({tag, ":result_const"}, bus.result, want);
`ifdef MONT_EXP_CYCLE_CNT_EN
      check({tag, ":cycles"}, bus.cycles, nmm * (lat + 1) + eff);
`else
      check({tag, ":cycles"}, bus.cycles, 0);
`endif
      // A start landing on the DONE cycle must be dropped.
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      check({tag, ":start_in_done"}, bus.busy, 0);
      repeat (2) @(negedge clk);
      check({tag, ":mm_count"}, mm_starts - base_starts, nmm);
      check({tag, ":done_once"}, done_pulses - base_done, 1);
      check({tag, ":result_held"}, bus.result, exp_res);
    end
  endtask

  initial begin
    int seen_starts;
    int base_done;
    longint rn;

    bus.start     = 1'b0;
    bus.x         = '0;
    bus.e         = '0;
    bus.e_len     = '0;
    bus.n         = '0;
    bus.r_n       = '0;
    bus.r2_n      = '0;
    bus.mm_done   = 1'b0;
    bus.mm_result = '0;

    #1;
    check("rst:busy", bus.busy, 0);
    check("rst:done", bus.done, 0);
    check("rst:result", bus.result, 0);
    check("rst:cycles", bus.cycles, 0);
    check("rst:mm_start", bus.mm_start, 0);
    check("rst:mm_a", bus.mm_a, 0);
    check("rst:mm_b", bus.mm_b, 0);
    check("rst:mm_m", bus.mm_m, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    do_job("t1", 4, 13, 4, 497, 5, 1'b0, 445);
    do_job("t2", 123, 0, 0, 497, 3, 1'b0, 1);
    do_job("t3a", 496, 1, 1, 497, 1, 1'b0, 496);
    do_job("t3b", 496, 1, 1, 497, 40, 1'b0, 496);
    do_job("t4", 2, 5, 3, 497, 6, 1'b1, 32);
    do_job("t6", 4, 13, 4, 497, 3, 1'b0, 445);

    // Reset while the first SQUARE is being issued; its product arrives after reset.
    mm_lat    = 40;
    bus.x     = WIDTH'(5);
    bus.e     = E_W'(16'hB3C5);
    bus.e_len = LEN_W'(8);
    bus.n     = WIDTH'(497);
    rn        = (longint'(1) << WIDTH) % 497;
    bus.r_n   = WIDTH'(rn);
    bus.r2_n  = WIDTH'((longint'(1) << (2 * WIDTH)) % 497);
    base_done = done_pulses;
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    seen_starts = 0;
    for (int c = 0; c < 400 && seen_starts < 2; c++) begin
      if (bus.mm_start) seen_starts++;
      if (seen_starts < 2) @(negedge clk);
    end
    check("t5:square_issued", seen_starts, 2);
    reset = 1'b1;
    #1;
    check("t5:busy_in_reset", bus.busy, 0);
    check("t5:mm_start_in_reset", bus.mm_start, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (60) @(negedge clk);
    check("t5:late_done_busy", bus.busy, 0);
    check("t5:late_done_no_done", done_pulses - base_done, 0);
    check("t5:result_cleared", bus.result, 0);
    do_job("t5b", 3, 4, 3, 497, 4, 1'b0, 81);

    for (int k = 0; k < 8; k++) begin
      longint n_r;
      longint x_r;
      longint e_r;
      int     len_r;
      int     lat_r;
      n_r   = longint'($urandom_range(3, 65535)) | 1;
      x_r   = longint'($urandom_range(0, 32'(n_r - 1)));
      e_r   = longint'($urandom_range(0, 65535));
      len_r = int'($urandom_range(0, 31));
      lat_r = int'($urandom_range(1, 40));
      do_job($sformatf("rnd%0d", k), x_r, e_r, len_r, n_r, lat_r, 1'b0, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
